// File: rtl/store_buffer.sv
// Write-back store queue owning the single data-memory port: loads bypass
// immediately, buffered stores drain in FIFO order whenever no load needs the port.
module store_buffer #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        st_valid,
   input  logic [ADDR_WIDTH-1:0]       st_addr,
   input  logic [DATA_WIDTH-1:0]       st_data,
   input  logic [2:0]                  st_funct3,
   output logic                        st_ready,
   input  logic                        ld_valid,
   input  logic [ADDR_WIDTH-1:0]       ld_addr,
   input  logic [2:0]                  ld_funct3,
   output logic                        ld_hazard,
   output logic                        mem_wr_en,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   output logic [DATA_WIDTH-1:0]       mem_wr_data,
   output logic [2:0]                  mem_funct3,
   output logic                        empty,
   output logic [$clog2(DEPTH):0]      count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] ent_addr   [DEPTH];
   logic [DATA_WIDTH-1:0] ent_data   [DEPTH];
   logic [2:0]            ent_funct3 [DEPTH];
   logic [DEPTH-1:0]      ent_valid;

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  enq;
   logic                  deq;
   logic                  addr_hit;
   logic                  load_sel;

   assign empty    = (count == '0);
   assign st_ready = (count < CNT_W'(DEPTH));
   assign enq      = st_valid && st_ready;
   assign deq      = mem_wr_en;

   // Word-granular match against buffered entries only; a store being
   // enqueued this cycle is deliberately not considered.
   always_comb begin
      addr_hit = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ent_valid[i] &&
             ent_addr[i][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]) begin
            addr_hit = 1'b1;
         end
      end
      ld_hazard = ld_valid && addr_hit;
   end

   assign load_sel = ld_valid && !ld_hazard;

   always_comb begin
      mem_wr_en   = 1'b0;
      mem_addr    = ld_addr;
      mem_funct3  = ld_funct3;
      mem_wr_data = '0;
      if (!empty) begin
         mem_wr_data = ent_data[rd_ptr];
      end
      if (!load_sel && !empty) begin
         mem_wr_en  = 1'b1;
         mem_addr   = ent_addr[rd_ptr];
         mem_funct3 = ent_funct3[rd_ptr];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ent_valid <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_addr[i]   <= '0;
            ent_data[i]   <= '0;
            ent_funct3[i] <= '0;
         end
      end else begin
         // enq and deq never target the same slot: enq needs a free slot,
         // deq needs an occupied one, and wr_ptr == rd_ptr only when empty or full.
         if (deq) begin
            ent_valid[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + PTR_W'(1);
         end
         if (enq) begin
            ent_addr[wr_ptr]   <= st_addr;
            ent_data[wr_ptr]   <= st_data;
            ent_funct3[wr_ptr] <= st_funct3;
            ent_valid[wr_ptr]  <= 1'b1;
            wr_ptr             <= wr_ptr + PTR_W'(1);
         end
         if (enq && !deq) begin
            count <= count + CNT_W'(1);
         end else if (deq && !enq) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-back store queue between the pipelined CPU's MEM stage and the data memory. It accepts committed stores (sb/sh/sw) and buffers them in a small circular FIFO. It owns the single data-memory port: it lets loads through immediately and drains buffered stores one per cycle whenever the port is not needed by a load. A load whose word address hits a buffered store raises a hazard, which stalls the pipeline until the matching entries have drained.

## Interface
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, store data width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- st_valid  in  1  MEM stage presents a store this cycle
- st_addr  in  ADDR_WIDTH  store byte address
- st_data  in  DATA_WIDTH  store data, unshifted (byte/half in low bits)
- st_funct3  in  3  store width code (000 sb, 001 sh, 010 sw)
- st_ready  out  1  buffer can accept a store (count < DEPTH)
- ld_valid  in  1  MEM stage presents a load this cycle
- ld_addr  in  ADDR_WIDTH  load byte address
- ld_funct3  in  3  load width code, passed to memory
- ld_hazard  out  1  load word address matches a buffered entry
- mem_wr_en  out  1  write strobe to data memory
- mem_addr  out  ADDR_WIDTH  shared read/write address to data memory
- mem_wr_data  out  DATA_WIDTH  write data to data memory
- mem_funct3  out  3  access width code to data memory
- empty  out  1  no buffered stores (used by fence/ecall drain)
- count  out  $clog2(DEPTH)+1  number of buffered stores

## Operation
- Storage: DEPTH entries of {addr, data, funct3, valid}; wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0; count tracks occupancy.
- Enqueue: st_valid && st_ready at a posedge writes the entry at wr_ptr, sets valid, and increments wr_ptr. st_funct3 is stored unchecked; the data memory ignores other codes.
- st_ready = (count < DEPTH). A dequeue in the same cycle does not free a slot for that cycle; st_ready stays 0 when full.
- st_valid while !st_ready: the store is not taken. The upstream must hold it (a pipeline stall driven externally).
- Hazard: ld_hazard = ld_valid && any valid entry has addr[ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]. The check is combinational and covers stored entries only, not a store being enqueued in the same cycle.
- Port arbitration is combinational:
  - load_sel = ld_valid && !ld_hazard.
  - When load_sel: mem_addr = ld_addr, mem_funct3 = ld_funct3, mem_wr_en = 0.
  - Otherwise, when !empty: drain the head entry. mem_addr, mem_wr_data and mem_funct3 come from entry[rd_ptr], and mem_wr_en = 1.
  - Otherwise: mem_addr = ld_addr, mem_funct3 = ld_funct3, mem_wr_en = 0.
  - mem_wr_data = entry[rd_ptr].data whenever not empty, else 0.
- Dequeue: when mem_wr_en = 1 at a posedge, clear entry[rd_ptr].valid and increment rd_ptr. The memory writes at the same edge.
- Enqueue and dequeue in the same cycle leave count unchanged and both pointers advance.
- A hazarding load never blocks draining, so it cannot deadlock. Entries drain in FIFO order until no match remains.
- Ordering: stores reach memory in program order. Loads that bypass the buffer never read a stale value, because any overlapping word forces a drain first.

## Timing
- Reset (async, immediate):
  - wr_ptr = rd_ptr = 0, count = 0, all valid = 0.
  - Outputs: empty = 1, st_ready = 1, mem_wr_en = 0, ld_hazard = 0, mem_wr_data = 0.
  - mem_addr/mem_funct3 follow ld_addr/ld_funct3.
- Reset asserted mid-operation discards all buffered stores. The data memory contents are untouched.
- Store latency: enqueued at edge N, eligible to drain in cycle N+1, written to memory at edge N+1 if no load takes the port.
- Load path adds zero cycles: ld_addr appears on mem_addr in the same cycle when load_sel = 1.
- Hazard stall: with k entries ahead of and including the last matching one, and no competing loads, ld_hazard deasserts after k drain edges.
- count, empty and st_ready update only at posedge or reset. ld_hazard and mem_* are combinational.

## Test plan
- Reset then idle: after reset, count = 0, empty = 1, st_ready = 1, mem_wr_en = 0. Reassert reset with 3 entries buffered: count returns to 0 and no further writes occur.
- Single sw: st_addr = 0x10, st_data = 0xDEADBEEF, funct3 = 010 at edge 0. Required: mem_wr_en = 1 with mem_addr = 0x10 in cycle 1, and a subsequent lw 0x10 reads 0xDEADBEEF.
- Fill and wrap: enqueue 4 stores to 0x00/0x04/0x08/0x0C with continuous load_sel loads. Required: st_ready = 0 at count = 4 and a 5th store is held. Release the loads: drains occur in order 0x00..0x0C, then 6 more stores wrap the pointers with correct order.
- Load hazard: buffer sb 0x21 = 0xAB behind sw 0x30. Issue lb 0x22. Required: ld_hazard = 1 for 2 cycles while both drain, then 0, and the load returns the memory word with the updated byte.
- Load priority: buffer 2 stores, hold ld_valid on non-matching address 0x100 for 5 cycles. Required: mem_wr_en = 0 and mem_addr = 0x100 throughout, count stays 2, and draining resumes the cycle ld_valid drops.
- Simultaneous enqueue/dequeue: count = 2, st_valid each cycle, no loads. Required: count stays 2 and stores reach memory in program order.
